// File: rtl/buffer_int_tr.sv
// buffer_int_tr: 16x16 transpose buffer shared by the horizontal and vertical
// interpolation passes. In write mode it stores one row per enabled cycle. In
// read mode it replays the stored matrix one row or one column per enabled cycle.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   enable        advance the buffer; when low, all state and outputs hold
//   direction     read orientation: 0 = rows, 1 = columns
//   modo_leitura  0 = write (load) mode, 1 = read mode
//   in_0..in_15   one row of samples; in_k goes to column k
//   out_0..out_15 registered read data
//   out_valid     (only with BUFFER_INT_VALID_EN) high for the cycle after an
//                 enabled read-mode edge
//
// Optional feature macro: BUFFER_INT_VALID_EN
module buffer_int_tr #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  direction,
    input  logic                  modo_leitura,
    input  logic [DATA_WIDTH-1:0] in_0,
    input  logic [DATA_WIDTH-1:0] in_1,
    input  logic [DATA_WIDTH-1:0] in_2,
    input  logic [DATA_WIDTH-1:0] in_3,
    input  logic [DATA_WIDTH-1:0] in_4,
    input  logic [DATA_WIDTH-1:0] in_5,
    input  logic [DATA_WIDTH-1:0] in_6,
    input  logic [DATA_WIDTH-1:0] in_7,
    input  logic [DATA_WIDTH-1:0] in_8,
    input  logic [DATA_WIDTH-1:0] in_9,
    input  logic [DATA_WIDTH-1:0] in_10,
    input  logic [DATA_WIDTH-1:0] in_11,
    input  logic [DATA_WIDTH-1:0] in_12,
    input  logic [DATA_WIDTH-1:0] in_13,
    input  logic [DATA_WIDTH-1:0] in_14,
    input  logic [DATA_WIDTH-1:0] in_15,
    output logic [DATA_WIDTH-1:0] out_0,
    output logic [DATA_WIDTH-1:0] out_1,
    output logic [DATA_WIDTH-1:0] out_2,
    output logic [DATA_WIDTH-1:0] out_3,
    output logic [DATA_WIDTH-1:0] out_4,
    output logic [DATA_WIDTH-1:0] out_5,
    output logic [DATA_WIDTH-1:0] out_6,
    output logic [DATA_WIDTH-1:0] out_7,
    output logic [DATA_WIDTH-1:0] out_8,
    output logic [DATA_WIDTH-1:0] out_9,
    output logic [DATA_WIDTH-1:0] out_10,
    output logic [DATA_WIDTH-1:0] out_11,
    output logic [DATA_WIDTH-1:0] out_12,
    output logic [DATA_WIDTH-1:0] out_13,
    output logic [DATA_WIDTH-1:0] out_14,
    output logic [DATA_WIDTH-1:0] out_15
`ifdef BUFFER_INT_VALID_EN
    ,
    output logic                  out_valid
`endif
);

    localparam int unsigned N  = 16;
    localparam int unsigned PW = 4;

    logic [DATA_WIDTH-1:0] mem  [N][N];
    logic [DATA_WIDTH-1:0] din  [N];
    logic [DATA_WIDTH-1:0] dout [N];
    logic [PW-1:0]         wr_row;
    logic [PW-1:0]         rd_idx;
    logic [1:0]            last_mode;

    logic                  mode_change_c;
    logic [PW-1:0]         wr_ptr_c;
    logic [PW-1:0]         rd_ptr_c;

    // Flatten the row input ports into an indexable array.
    assign din[0]  = in_0;
    assign din[1]  = in_1;
    assign din[2]  = in_2;
    assign din[3]  = in_3;
    assign din[4]  = in_4;
    assign din[5]  = in_5;
    assign din[6]  = in_6;
    assign din[7]  = in_7;
    assign din[8]  = in_8;
    assign din[9]  = in_9;
    assign din[10] = in_10;
    assign din[11] = in_11;
    assign din[12] = in_12;
    assign din[13] = in_13;
    assign din[14] = in_14;
    assign din[15] = in_15;

    assign out_0  = dout[0];
    assign out_1  = dout[1];
    assign out_2  = dout[2];
    assign out_3  = dout[3];
    assign out_4  = dout[4];
    assign out_5  = dout[5];
    assign out_6  = dout[6];
    assign out_7  = dout[7];
    assign out_8  = dout[8];
    assign out_9  = dout[9];
    assign out_10 = dout[10];
    assign out_11 = dout[11];
    assign out_12 = dout[12];
    assign out_13 = dout[13];
    assign out_14 = dout[14];
    assign out_15 = dout[15];

    // Any change of {mode, direction} restarts the active pointer at index 0.
    assign mode_change_c = ({modo_leitura, direction} != last_mode);
    assign wr_ptr_c      = mode_change_c ? '0 : wr_row;
    assign rd_ptr_c      = mode_change_c ? '0 : rd_idx;

    // Storage, pointers and registered read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    mem[PW'(r)][PW'(c)] <= '0;
                end
                dout[PW'(r)] <= '0;
            end
            wr_row    <= '0;
            rd_idx    <= '0;
            last_mode <= 2'b00;
        end else if (enable) begin
            last_mode <= {modo_leitura, direction};
            if (!modo_leitura) begin
                for (int unsigned c = 0; c < N; c++) begin
                    mem[wr_ptr_c][PW'(c)] <= din[PW'(c)];
                end
                wr_row <= wr_ptr_c + PW'(1);
                if (mode_change_c) begin
                    rd_idx <= '0;
                end
            end else begin
                for (int unsigned k = 0; k < N; k++) begin
                    dout[PW'(k)] <= direction ? mem[PW'(k)][rd_ptr_c]
                                              : mem[rd_ptr_c][PW'(k)];
                end
                rd_idx <= rd_ptr_c + PW'(1);
            end
        end
    end

`ifdef BUFFER_INT_VALID_EN
    // One-cycle pulse after every enabled read-mode edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= enable & modo_leitura;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_int_tr.sv
// Scoreboard bench for buffer_int_tr: the driver updates a matrix-level model on
// every clock and queues the expected outputs; a monitor compares after each edge.
module tb_buffer_int_tr;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 16;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          direction;
    logic          modo_leitura;
    logic [DW-1:0] in_a [N];
    logic [DW-1:0] o    [N];
    logic          ov;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the matrix, the visible outputs, and the current
    // {mode,direction} run with the number of enabled edges spent in it.
    logic [DW-1:0] mem_m [N][N];
    logic [DW-1:0] out_m [N];
    logic [1:0]    run_mode;
    int            run_cnt;
    logic          val_m;

    logic [DW*N-1:0] q_d [$];
    logic            q_v [$];
    bit              started = 0;
    logic [DW-1:0]   row_v [N];

    buffer_int_tr #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .direction(direction),
        .modo_leitura(modo_leitura),
        .in_0(in_a[0]),   .in_1(in_a[1]),   .in_2(in_a[2]),   .in_3(in_a[3]),
        .in_4(in_a[4]),   .in_5(in_a[5]),   .in_6(in_a[6]),   .in_7(in_a[7]),
        .in_8(in_a[8]),   .in_9(in_a[9]),   .in_10(in_a[10]), .in_11(in_a[11]),
        .in_12(in_a[12]), .in_13(in_a[13]), .in_14(in_a[14]), .in_15(in_a[15]),
        .out_0(o[0]),   .out_1(o[1]),   .out_2(o[2]),   .out_3(o[3]),
        .out_4(o[4]),   .out_5(o[5]),   .out_6(o[6]),   .out_7(o[7]),
        .out_8(o[8]),   .out_9(o[9]),   .out_10(o[10]), .out_11(o[11]),
        .out_12(o[12]), .out_13(o[13]), .out_14(o[14]), .out_15(o[15])
`ifdef BUFFER_INT_VALID_EN
        , .out_valid(ov)
`endif
    );

`ifndef BUFFER_INT_VALID_EN
    assign ov = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW*N-1:0] pack_dut();
        logic [DW*N-1:0] v;
        for (int k = 0; k < int'(N); k++) v[k*DW +: DW] = o[k];
        return v;
    endfunction

    function automatic logic [DW*N-1:0] pack_model();
        logic [DW*N-1:0] v;
        for (int k = 0; k < int'(N); k++) v[k*DW +: DW] = out_m[k];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, queue expectation.
    task automatic step(input logic r, input logic e, input logic m, input logic d);
        int idx;
        @(negedge clock);
        reset        = r;
        enable       = e;
        modo_leitura = m;
        direction    = d;
        for (int k = 0; k < int'(N); k++) in_a[k] = row_v[k];
        if (!r) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) mem_m[i][j] = '0;
                out_m[i] = '0;
            end
            run_mode = 2'b00;
            run_cnt  = 0;
            val_m    = 1'b0;
            #1;
            n_chk++;
            if (pack_dut() != '0) begin
                n_fail++;
                $display("FAIL reset_immediate: got %h expected 0", pack_dut());
            end
        end else if (e) begin
            if ({m, d} != run_mode) begin
                run_mode = {m, d};
                run_cnt  = 0;
            end
            idx     = run_cnt % int'(N);
            run_cnt = run_cnt + 1;
            if (!m) begin
                for (int k = 0; k < int'(N); k++) mem_m[idx][k] = row_v[k];
            end else begin
                for (int k = 0; k < int'(N); k++)
                    out_m[k] = d ? mem_m[k][idx] : mem_m[idx][k];
            end
            val_m = m;
        end else begin
            val_m = 1'b0;
        end
        q_d.push_back(pack_model());
        q_v.push_back(val_m);
        started = 1;
        @(posedge clock);
    endtask

    // Monitor: every edge the DUT presents outputs; compare with the oldest expectation.
    initial begin
        logic [DW*N-1:0] e_d;
        logic            e_v;
        forever begin
            @(posedge clock);
            #1;
            if (started) begin
                n_chk++;
                if (q_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: got output %h with no expectation", pack_dut());
                end else begin
                    e_d = q_d.pop_front();
                    e_v = q_v.pop_front();
                    if (pack_dut() !== e_d) begin
                        n_fail++;
                        $display("FAIL outputs: got %h expected %h at %0t", pack_dut(), e_d, $time);
                    end
`ifdef BUFFER_INT_VALID_EN
                    n_chk++;
                    if (ov !== e_v) begin
                        n_fail++;
                        $display("FAIL out_valid: got %b expected %b at %0t", ov, e_v, $time);
                    end
`endif
                end
            end
        end
    end

    task automatic set_row(input int base);
        for (int k = 0; k < int'(N); k++) row_v[k] = DW'(base + k);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; modo_leitura = 1'b0; direction = 1'b0;
        set_row(0);
        for (int k = 0; k < int'(N); k++) in_a[k] = '0;

        step(0, 0, 0, 0);
        step(0, 1, 1, 0);

        // Load rows with in_k = 16r + k.
        for (int r = 0; r < 16; r++) begin set_row(16 * r); step(1, 1, 0, 0); end
        set_row(0);

        // Row read with wrap on the 17th read.
        for (int j = 0; j < 17; j++) begin
            step(1, 1, 1, 0);
            #1;
            if (j == 0)  chk("row0_out3", int'(o[3]), 3);
            if (j == 9)  chk("row9_out2", int'(o[2]), 146);
            if (j == 16) chk("row_wrap_out5", int'(o[5]), 5);
        end

        // Column read with wrap.
        for (int j = 0; j < 17; j++) begin
            step(1, 1, 1, 1);
            #1;
            if (j == 0) begin
                chk("col0_out1", int'(o[1]), 16);
                chk("col0_out15", int'(o[15]), 240);
            end
            if (j == 7)  chk("col7_out3", int'(o[3]), 55);
            if (j == 16) chk("col_wrap_out2", int'(o[2]), 32);
        end

        // Mode switch restart: 5 row reads, then column 0.
        for (int j = 0; j < 5; j++) step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        #1 chk("switch_col0_out2", int'(o[2]), 32);

        // Enable hold in column read.
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        for (int j = 0; j < 3; j++) begin
            step(1, 0, 1, 1);
            #1 chk("hold_out1", int'(o[1]), 18);
        end
        step(1, 1, 1, 1);
        #1 chk("resume_col3_out1", int'(o[1]), 19);

        // Write wrap: 17th row overwrites row 0.
        for (int r = 0; r < 16; r++) begin set_row(16 * r); step(1, 1, 0, 0); end
        set_row(200);
        step(1, 1, 0, 0);
        set_row(0);
        step(1, 1, 1, 0);
        #1 chk("wwrap_row0_out4", int'(o[4]), 204);
        step(1, 1, 1, 0);
        #1 chk("wwrap_row1_out4", int'(o[4]), 20);

        // Mid-stream reset, then reads return zero.
        step(1, 1, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        for (int j = 0; j < 3; j++) begin
            step(1, 1, 1, 0);
            #1 chk("post_reset_out7", int'(o[7]), 0);
        end

        // Randomized traffic.
        begin
            logic m, d, r, e;
            m = 1'b0; d = 1'b0;
            for (int i = 0; i < 500; i++) begin
                for (int k = 0; k < int'(N); k++) row_v[k] = DW'($urandom);
                if ($urandom_range(0, 7) == 0) m = ~m;
                if ($urandom_range(0, 9) == 0) d = ~d;
                e = ($urandom_range(0, 5) != 0);
                r = ($urandom_range(0, 149) != 0);
                step(r, e, m, d);
            end
        end

        step(1, 0, 0, 0);
        #2;
        chk("scoreboard_drained", q_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
